// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3 initiator.
//
// Turns a valid/ready command into one APB SETUP/ACCESS transfer and hands
// back a valid/ready response. PREADY wait states are honoured. PSLVERR is
// reported as rsp_err. A transfer that stalls for TIMEOUT ACCESS cycles is
// aborted and reported with rsp_err and rsp_timeout both set.
//
// Ports
//   PCLK, PRESETn         clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write/addr/wdata  command payload
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata/err/timeout response payload
//   PSEL..PWDATA          APB request outputs (all registered)
//   PRDATA/PREADY/PSLVERR APB completion inputs
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL=1, PENABLE=0 for one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
// RESP   | rsp_valid high until rsp_ready

module apb_master #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic [15:0] PADDR,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT - 1) : '0;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [15:0]   paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q is low for the first cycle after reset release,
                // so a command present then is not yet accepted.
                if (cmd_valid && cmd_ready_q) begin
                    state_d    = ST_SETUP;
                    wait_cnt_d = '0;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    pwrite_d   = cmd_write;
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? 32'h0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
                    state_d       = ST_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'h0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (TO_EN) begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // cmd_ready is registered: high exactly while the FSM sits in IDLE.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 16'h0;
            pwdata_q      <= 32'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
